// File: rtl/piso_serializer_if.sv
// Parallel-load handshake plus serial output bundle for the PISO serializer.
// slave = serializer side, master = upstream producer / stream consumer side.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] parallel_in;
    logic             serial_out;
    logic             serial_valid;
    logic             done;

    modport slave (
        input  load_valid, parallel_in,
        output load_ready, serial_out, serial_valid, done
    );

    modport master (
        output load_valid, parallel_in,
        input  load_ready, serial_out, serial_valid, done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: one word per WIDTH cycles, gapless when the
// next word is accepted on the last-bit edge.
module piso_serializer #(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    piso_serializer_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             serial_out_q, serial_out_d;
    logic             serial_valid_q, serial_valid_d;
    logic             load_ready;
    logic             accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            sreg_q         <= '0;
            serial_out_q   <= IDLE_LEVEL;
            serial_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sreg_q         <= sreg_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
        end
    end

    // Ready also in the last-bit cycle so a waiting word follows with no gap.
    always_comb begin
        load_ready = !reset && ((state_q == IDLE) || (cnt_q == LAST));
        accept     = bus.load_valid && load_ready;
        state_d    = state_q;
        cnt_d      = cnt_q;
        sreg_d     = sreg_q;

        if (accept) begin
            state_d = SHIFT;
            cnt_d   = '0;
            sreg_d  = bus.parallel_in;
        end else if (state_q == SHIFT) begin
            if (cnt_q == LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (MSB_FIRST) sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                else           sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
            end
        end

        serial_valid_d = (state_d == SHIFT);
        if (state_d != SHIFT)  serial_out_d = IDLE_LEVEL;
        else if (MSB_FIRST)    serial_out_d = sreg_d[WIDTH-1];
        else                   serial_out_d = sreg_d[0];
    end

    assign bus.load_ready   = load_ready;
    assign bus.serial_out   = serial_out_q;
    assign bus.serial_valid = serial_valid_q;
    assign bus.done         = (state_q == SHIFT) && (cnt_q == LAST);
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations driven in lockstep, checked
// against constant vectors, hand sequences and a bit-queue reference model.
module tb_piso_serializer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(4)) if0 ();
    piso_serializer_if #(.WIDTH(4)) if1 ();
    piso_serializer_if #(.WIDTH(8)) if2 ();

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0))
        u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0))
        u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1))
        u2 (.clk(clk), .reset(reset), .bus(if2.slave));

    int errors = 0;
    int checks = 0;

    // Model: queue of bits still to appear on serial_out; front = bit on the wire now.
    bit q0[$];
    bit q1[$];
    bit q2[$];
    logic rdy_pre0;

    typedef struct {
        bit       rst;
        bit       lv;
        bit [3:0] p4;
        bit [7:0] p8;
        bit       rdy0;
        bit       o0, v0, d0;
        bit       o1;
        bit       o2, v2, d2;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mdl(input bit rst, input bit lv, input bit [7:0] w, input int wd,
                       input bit msb, inout bit q[$]);
        bit acc;
        acc = lv && !rst && (q.size() <= 1);
        if (rst) q.delete();
        else begin
            if (q.size() > 0) void'(q.pop_front());
            if (acc)
                for (int i = 0; i < wd; i++) q.push_back(msb ? w[wd-1-i] : w[i]);
        end
    endtask

    task automatic chk_out(input string nm, input logic o, input logic v, input logic d,
                           input bit q[$], input bit idle);
        check({nm, ".serial_valid"}, v, q.size() > 0);
        check({nm, ".serial_out"}, o, (q.size() > 0) ? q[0] : idle);
        check({nm, ".done"}, d, q.size() == 1);
    endtask

    // One clock: drive, check ready before the edge, edge, advance model, check outputs.
    task automatic cycle(input bit rst, input bit lv, input bit [3:0] p4, input bit [7:0] p8);
        reset = rst;
        if0.load_valid = lv; if0.parallel_in = p4;
        if1.load_valid = lv; if1.parallel_in = p4;
        if2.load_valid = lv; if2.parallel_in = p8;
        #1;
        rdy_pre0 = if0.load_ready;
        check("u0.load_ready", if0.load_ready, !rst && (q0.size() <= 1));
        check("u1.load_ready", if1.load_ready, !rst && (q1.size() <= 1));
        check("u2.load_ready", if2.load_ready, !rst && (q2.size() <= 1));
        @(posedge clk);
        mdl(rst, lv, {4'b0, p4}, 4, 1'b1, q0);
        mdl(rst, lv, {4'b0, p4}, 4, 1'b0, q1);
        mdl(rst, lv, p8, 8, 1'b1, q2);
        #1;
        chk_out("u0", if0.serial_out, if0.serial_valid, if0.done, q0, 1'b0);
        chk_out("u1", if1.serial_out, if1.serial_valid, if1.done, q1, 1'b0);
        chk_out("u2", if2.serial_out, if2.serial_valid, if2.done, q2, 1'b1);
    endtask

    initial begin
        bit [3:0] bits_a;
        // rst lv p4 p8 | rdy0 | o0 v0 d0 | o1 | o2 v2 d2
        tbl[0]  = '{1, 1, 4'b1011, 8'hA5, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[1]  = '{0, 1, 4'b1011, 8'hA5, 1, 1, 1, 0, 1, 1, 1, 0};
        tbl[2]  = '{0, 1, 4'b1011, 8'hA5, 0, 0, 1, 0, 1, 0, 1, 0};
        tbl[3]  = '{0, 1, 4'b1011, 8'hA5, 0, 1, 1, 0, 0, 1, 1, 0};
        tbl[4]  = '{0, 1, 4'b1011, 8'hA5, 0, 1, 1, 1, 1, 0, 1, 0};
        tbl[5]  = '{0, 1, 4'b0110, 8'hA5, 1, 0, 1, 0, 0, 0, 1, 0};
        tbl[6]  = '{0, 0, 4'b0000, 8'h00, 0, 1, 1, 0, 1, 1, 1, 0};
        tbl[7]  = '{0, 0, 4'b0000, 8'h00, 0, 1, 1, 0, 1, 0, 1, 0};
        tbl[8]  = '{0, 0, 4'b0000, 8'h00, 0, 0, 1, 1, 0, 1, 1, 1};
        tbl[9]  = '{0, 0, 4'b0000, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0};
        tbl[10] = '{0, 0, 4'b0000, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0};

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].rst, tbl[i].lv, tbl[i].p4, tbl[i].p8);
            check($sformatf("vec%0d.u0.load_ready", i), rdy_pre0, tbl[i].rdy0);
            check($sformatf("vec%0d.u0.serial_out", i), if0.serial_out, tbl[i].o0);
            check($sformatf("vec%0d.u0.serial_valid", i), if0.serial_valid, tbl[i].v0);
            check($sformatf("vec%0d.u0.done", i), if0.done, tbl[i].d0);
            check($sformatf("vec%0d.u1.serial_out", i), if1.serial_out, tbl[i].o1);
            check($sformatf("vec%0d.u2.serial_out", i), if2.serial_out, tbl[i].o2);
            check($sformatf("vec%0d.u2.serial_valid", i), if2.serial_valid, tbl[i].v2);
            check($sformatf("vec%0d.u2.done", i), if2.done, tbl[i].d2);
        end

        // Stall: word 1100 in flight while parallel_in toggles; 1001 taken at the last bit.
        cycle(0, 1, 4'b1100, 8'h3C);
        bits_a = 4'b1100;
        for (int k = 1; k < 4; k++) begin
            cycle(0, 1, 4'($urandom), 8'($urandom));
            check($sformatf("stall%0d.ready", k), rdy_pre0, 1'b0);
            check($sformatf("stall%0d.bit", k), if0.serial_out, bits_a[3-k]);
        end
        cycle(0, 1, 4'b1001, 8'h00);
        check("stall.accept_last", rdy_pre0, 1'b1);
        check("stall.next_bit0", if0.serial_out, 1'b1);
        cycle(0, 0, 4'b1111, 8'h00);
        check("stall.next_bit1", if0.serial_out, 1'b0);
        for (int k = 0; k < 12; k++) cycle(0, 0, 4'b0, 8'h0);

        // Reset mid-word after two bits of 1011.
        cycle(0, 1, 4'b1011, 8'h00);
        cycle(0, 0, 4'b0000, 8'h00);
        check("midrst.bit1", if0.serial_out, 1'b0);
        cycle(1, 1, 4'b1111, 8'hFF);
        check("midrst.out", if0.serial_out, 1'b0);
        check("midrst.valid", if0.serial_valid, 1'b0);
        check("midrst.done", if0.done, 1'b0);
        check("midrst.u2_out_idle", if2.serial_out, 1'b1);
        cycle(0, 0, 4'b0000, 8'h00);
        check("midrst.ready_after", rdy_pre0, 1'b1);
        check("midrst.no_done", if0.done, 1'b0);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++)
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                  4'($urandom), 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out serializer that accepts a WIDTH-bit word through a valid/ready handshake and drives it out one bit per clock. It sits directly upstream of the team's SIPO shift register and feeds that block's serial input. Back-to-back words stream with no idle gap, so a downstream deserializer sees one contiguous bit stream. A framing strobe (`serial_valid`) and an end-of-word pulse (`done`) let the consumer align words.

## Interface
Parameters:
- `WIDTH`, default 4, word width in bits; must be ≥ 2.
- `MSB_FIRST`, default 1; 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
- `IDLE_LEVEL`, default 0, value driven on `serial_out` when no word is in flight.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `load_valid` input 1: upstream presents `parallel_in`.
- `load_ready` output 1: serializer can accept a word this cycle.
- `parallel_in` input WIDTH: word to serialize; sampled only on an accept edge.
- `serial_out` output 1: current serial bit (registered).
- `serial_valid` output 1: `serial_out` carries a data bit this cycle (registered).
- `done` output 1: high in the cycle the final bit of a word is on `serial_out`.

## Operation
- Two-state FSM: IDLE and SHIFT. Internal state: WIDTH-bit shift register, plus a bit counter `cnt` of width clog2(WIDTH).
- `load_ready` is combinational:
  - 0 while `reset` = 1.
  - Otherwise 1 when state = IDLE, or when state = SHIFT and `cnt` = WIDTH-1 (last bit).
  - 0 at all other times.
- Accept: `load_valid` & `load_ready` sampled high at a rising edge. On that edge:
  - Capture `parallel_in` into the shift register.
  - Drive the first bit (MSB or LSB per `MSB_FIRST`) on `serial_out`.
  - Set `serial_valid` = 1, `cnt` = 0, state = SHIFT.
- Each subsequent edge in SHIFT with `cnt` < WIDTH-1:
  - Shift by one position toward the output end.
  - Drive the next bit and increment `cnt`.
- Edge in SHIFT with `cnt` = WIDTH-1:
  - With an accept on the same edge: load the new word exactly as above, giving a gapless stream.
  - Without an accept: state = IDLE, `serial_out` = IDLE_LEVEL, `serial_valid` = 0.
- `done` = (state = SHIFT) & (`cnt` = WIDTH-1). It is exactly one cycle per word, including back-to-back words.
- `parallel_in` changes outside accept edges have no effect on the word in flight.
- `load_valid` held high while `load_ready` = 0 is simply stalled. No data is lost or duplicated, and upstream must hold `parallel_in` stable until accepted.
- Word order is preserved; the serializer holds at most one word.

## Timing
- Reset (edge with `reset` = 1):
  - State = IDLE, `cnt` = 0, shift register = 0.
  - `serial_out` = IDLE_LEVEL, `serial_valid` = 0, `done` = 0.
  - `load_ready` = 0 during reset and 1 in the first cycle after `reset` falls.
- Latency: the first bit appears on `serial_out` in the cycle immediately after the accept edge. A word occupies exactly WIDTH consecutive cycles.
- Throughput: 1 bit/clock sustained; a word can be accepted every WIDTH cycles.
- Reset mid-word: the word is aborted at the next edge. Outputs return to their reset values, and no `done` is emitted for the aborted word.
- Reset together with `load_valid` = 1: reset wins and the word is not captured.
- Accept in the same cycle reset deasserts is not possible, because `load_ready` = 0 while `reset` = 1.

## Test plan
- Reset and idle behaviour:
  - Stimulus: WIDTH=4, MSB_FIRST=1; hold reset 1 cycle, then accept 4'b1011.
  - Required: `serial_out` = 1,0,1,1 on the 4 cycles after the accept edge; `serial_valid` = 1 on those cycles; `done` high only on the 4th; then `serial_out` = 0 and `serial_valid` = 0.
- Back-to-back streaming:
  - Stimulus: `load_valid` held high with 4'b1011, then 4'b0110 presented once `load_ready` rises in the last-bit cycle.
  - Required: 8 contiguous valid bits 1,0,1,1,0,1,1,0 and two `done` pulses, 4 cycles apart.
- LSB-first ordering:
  - Stimulus: MSB_FIRST=0, accept 4'b1011.
  - Required: `serial_out` = 1,1,0,1.
- Stall and input stability:
  - Stimulus: `load_valid` held high and `parallel_in` toggled every cycle while a word is in flight.
  - Required: `load_ready` = 0 for cycles 1–3 of the word; the in-flight bits are unchanged; the next word is captured only at the last-bit edge.
- Reset mid-word:
  - Stimulus: accept 4'b1011, assert reset after 2 bits have been sent.
  - Required: at the next edge `serial_out` = 0, `serial_valid` = 0, `done` never pulses; `load_ready` = 1 in the cycle after reset drops.
- Wider word:
  - Stimulus: WIDTH=8, IDLE_LEVEL=1, accept 8'hA5.
  - Required: `serial_out` = 1,0,1,0,0,1,0,1; `done` on the 8th bit; `serial_out` = 1 when idle.
